// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: holds the PC, reads instruction memory, hands
// each instruction to decode and forms the next PC from branch/jump controls.
module pc_fetch_unit #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter int unsigned         TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            pc_src,
    input  logic [1:0]      jump,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [31:0]     instret
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [1:0]      fault_code_q, fault_code_d;
    logic [31:0]     instret_q, instret_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] next_pc;

    // jalr outranks jal/branch; jump=11 is treated as no jump
    always_comb begin
        jalr_sum = rs1_data + imm_ext;
        if (jump == 2'b10) begin
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (jump == 2'b01 || pc_src) begin
            next_pc = pc_q + imm_ext;
        end else begin
            next_pc = pc_q + XLEN'(4);
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_code_d  = fault_code_q;
        instret_d     = instret_q;
        cnt_d         = cnt_q;
        case (state_q)
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // a response on the final counted cycle still wins over timeout
                if (imem_valid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        fault_code_d = 2'b10;
                        state_d      = S_FAULT;
                    end
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    instr_valid_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_code_d = 2'b01;
                        state_d      = S_FAULT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_REQ;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fault_code_q  <= 2'b00;
            instret_q     <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_code_q  <= fault_code_d;
            instret_q     <= instret_d;
            cnt_q         <= cnt_d;
        end
    end

    // the request strobe is gated by rst so it stays low while reset is held
    assign imem_req    = (state_q == S_REQ) && !rst;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign fault       = (state_q == S_FAULT);
    assign fault_code  = fault_code_q;
    assign instret     = instret_q;

endmodule
